// File: rtl/fp16_stream_accum.sv
// fp16_stream_accum: sequential FP16 packet accumulator.
// Holds a running sum and the most recent operand in registers. These feed an
// external combinational FP16 adder, and the adder result is registered back
// as the new running sum. When the last operand of a packet has been added,
// the total and a saturating element count are presented on a valid/ready
// output port.
module fp16_stream_accum #(
  parameter int FLOAT_WIDTH = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FLOAT_WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic [FLOAT_WIDTH-1:0] add_a,
  output logic [FLOAT_WIDTH-1:0] add_b,
  input  logic [FLOAT_WIDTH-1:0] add_res,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FLOAT_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]   out_count,
  output logic                   out_sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q,     state_d;
  logic [FLOAT_WIDTH-1:0] acc_q,       acc_d;
  logic [FLOAT_WIDTH-1:0] op_q,        op_d;
  logic                   last_q,      last_d;
  logic [CNT_WIDTH-1:0]   cnt_q,       cnt_d;
  logic                   sat_q,       sat_d;
  logic                   out_valid_q, out_valid_d;
  logic [FLOAT_WIDTH-1:0] out_data_q,  out_data_d;
  logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;
  logic                   out_sat_q,   out_sat_d;

  logic in_fire;
  logic out_fire;

  // The adder path is register-to-register. The sum and the operand go straight out.
  assign add_a     = acc_q;
  assign add_b     = op_q;
  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Next-state and datapath update for the IDLE/ACCUM/ADD/DONE sequencer.
  always_comb begin
    // NOTE: every signal gets a hold default first, so a branch that misses one cannot infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;

    unique case (state_q)
      IDLE, ACCUM: begin
        // acc/cnt/sat are already zero in IDLE (cleared on leaving DONE),
        // so the first element needs no special case: 0 + x = x.
        if (in_fire) begin
          op_d   = in_data;
          last_d = in_last;
          if (&cnt_q) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          state_d = ADD;
        end
      end

      ADD: begin
        acc_d = add_res;
        if (last_q) begin
          out_data_d  = add_res;
          out_count_d = cnt_q;
          out_sat_d   = sat_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = ACCUM;
        end
      end

      DONE: begin
        // Output fields stay frozen until the handshake. Then all
        // accumulation state is cleared, ready for the next packet.
        if (out_fire) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          op_d        = '0;
          cnt_d       = '0;
          sat_d       = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register. Synchronous reset wins over any same-cycle handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_fp16_stream_accum.sv
// tb_fp16_stream_accum: self-checking bench for fp16_stream_accum.
// A behavioural FP16 adder, built on real arithmetic, drives add_res. The
// reference model tracks each packet as a plain integer sum and element count.
// Operands are small integers, so every partial sum is exact in FP16.
module tb_fp16_stream_accum;

  localparam int FW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_data;
  logic          in_last;
  logic [FW-1:0] add_a;
  logic [FW-1:0] add_b;
  logic [FW-1:0] add_res;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_sat;

  int n_cmp  = 0;
  int n_fail = 0;
  int ref_sum;

  fp16_stream_accum #(.FLOAT_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_res   (add_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  // Integer -> FP16 encoding. Valid for |k| < 2048; zero encodes as +0.
  function automatic logic [15:0] int_to_fp16(input int k);
    int n;
    int p;
    int mant;
    n = (k < 0) ? -k : k;
    if (n == 0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 12; i++) if (n[i]) p = i;
    mant = (n << (10 - p)) & 32'h3FF;
    return {(k < 0), 5'(p + 15), 10'(mant)};
  endfunction

  function automatic real fp16_to_real(input logic [15:0] b);
    real v;
    int  e;
    e = (b[14:10] == 5'd0) ? -24 : (int'(b[14:10]) - 25);
    v = (b[14:10] == 5'd0) ? real'(b[9:0]) : real'(1024 + int'(b[9:0]));
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[15] ? -v : v;
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    return int_to_fp16($rtoi(fp16_to_real(a) + fp16_to_real(b)));
  endfunction

  // Stand-in for the downstream combinational adder.
  always_comb add_res = fp16_add(add_a, add_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand. The task returns in the ADD cycle that follows the handshake.
  task automatic send(input int val, input bit last, input int gap);
    int t;
    repeat (gap) begin
      step();
      check("hold_add_a", add_a, int_to_fp16(ref_sum));
    end
    in_valid = 1'b1;
    in_data  = int_to_fp16(val);
    in_last  = last;
    t = 0;
    while (!in_ready && t < 10) begin step(); t++; end
    check("in_ready_wait", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    check("add_in_ready", in_ready, 0);
    check("add_a_partial", add_a, int_to_fp16(ref_sum));
    check("add_b_operand", add_b, int_to_fp16(val));
    ref_sum += val;
  endtask

  // Send a full packet, check the result and its latency, apply backpressure, then drain.
  task automatic run_packet(input int vals[$], input int bp, input int max_gap);
    int n;
    int last_val;
    n = vals.size();
    ref_sum = 0;
    last_val = vals[n-1];
    for (int i = 0; i < n; i++)
      send(vals[i], (i == n - 1), $urandom_range(0, max_gap));
    check("latency_n1", out_valid, 0);
    step();
    check("latency_n2", out_valid, 1);
    check("out_data", out_data, int_to_fp16(ref_sum));
    check("out_count", out_count, (n > 255) ? 255 : n);
    check("out_sat", out_sat, (n >= 256) ? 1 : 0);
    for (int i = 0; i < bp; i++) begin
      in_valid = $urandom_range(0, 1);
      in_data  = $urandom;
      in_last  = 1'b1;
      step();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, int_to_fp16(ref_sum));
      check("bp_count", out_count, (n > 255) ? 255 : n);
      check("bp_in_ready", in_ready, 0);
      check("bp_add_b", add_b, int_to_fp16(last_val));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    check("done_in_ready", in_ready, 0);
    step();
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
    check("drain_add_a", add_a, 16'h0000);
    check("drain_add_b", add_b, 16'h0000);
  endtask

  initial begin
    int q[$];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state.
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_count", out_count, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_add_a", add_a, 16'h0000);
    check("rst_add_b", add_b, 16'h0000);

    // Sanity-check the integer encoder against the known constants.
    check("enc_1", int_to_fp16(1), 16'h3C00);
    check("enc_3", int_to_fp16(3), 16'h4200);
    check("enc_m3", int_to_fp16(-3), 16'hC200);

    // 1 + 2 = 3.
    q = '{1, 2};
    run_packet(q, 0, 0);
    check("dir_sum3", out_data, 16'h4200);

    // 1 + 2 - 3 = 0, then single element 2. This shows the clear between packets.
    q = '{1, 2, -3};
    run_packet(q, 0, 1);
    q = '{2};
    run_packet(q, 0, 0);

    // Backpressure for 5 cycles, with in_valid pulses that must be ignored.
    q = '{4, -7, 9};
    run_packet(q, 5, 2);

    // Reset mid-packet after 2 of 4 operands, with a same-cycle handshake attempt.
    ref_sum = 0;
    send(5, 1'b0, 0);
    send(7, 1'b0, 0);
    step();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = int_to_fp16(11);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_add_a", add_a, 16'h0000);
    check("mid_rst_add_b", add_b, 16'h0000);
    check("mid_rst_out_valid", out_valid, 0);
    q = '{-1};
    run_packet(q, 0, 0);

    // Reset during an ADD cycle that carries the last operand: no output may appear.
    ref_sum = 0;
    send(6, 1'b1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("add_rst_out_valid", out_valid, 0);
    check("add_rst_add_a", add_a, 16'h0000);
    step();
    check("add_rst_no_out", out_valid, 0);

    // Counter boundaries: 255 (no saturation), 256 and 257 (saturated).
    q = {};
    for (int i = 0; i < 255; i++) q.push_back(0);
    run_packet(q, 0, 0);
    q.push_back(0);
    run_packet(q, 0, 0);
    q.push_back(0);
    run_packet(q, 1, 0);

    // Random packets with random gaps and random backpressure.
    for (int p = 0; p < 25; p++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(1, 6)); i++)
        q.push_back(int'($urandom_range(0, 40)) - 20);
      run_packet(q, $urandom_range(0, 3), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
